// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// level interrupt (one-shot) or single-cycle pulse (auto-reload).
module mmio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  input  logic        sel,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  state_e      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic        pend_q;
  logic [31:0] preset_q;
  logic [31:0] preset_d;
  logic [31:0] count_q;

  logic wr_any;
  logic wr_ctrl;
  logic wr_preset;
  logic auto_reload;

  // Only addr[3:2] selects a register; the rest of the address is ignored.
  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign wr_any      = sel & (|byteen);
  assign wr_ctrl     = wr_any & (addr[3:2] == 2'd0);
  assign wr_preset   = wr_any & (addr[3:2] == 2'd1);
  // Modes 10/11 fall back to one-shot.
  assign auto_reload = (mode_q == 2'b01);

  // Byte-merged next value of PRESET.
  always_comb begin
    preset_d = preset_q;
    for (int k = 0; k < 4; k++) begin
      if (wr_preset && byteen[k]) begin
        preset_d[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

  // Timer FSM and register file; CPU CTRL writes are applied last so they win.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      preset_q <= preset_d;
      case (state_q)
        StIdle: begin
          if (en_q) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!en_q) begin
            state_q <= StIdle;
          end else if (count_q <= 32'd1) begin
            count_q <= '0;
            state_q <= StInt;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        StInt: begin
          if (auto_reload) begin
            state_q <= StLoad;
          end else begin
            en_q    <= 1'b0;
            pend_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (wr_ctrl) begin
        pend_q <= 1'b0;
        if (byteen[0]) begin
          en_q   <= wdata[0];
          mode_q <= wdata[2:1];
          im_q   <= wdata[3];
        end
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = '0;
      endcase
    end
  end

  assign irq = im_q & (pend_q | ((state_q == StInt) & auto_reload));

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a timeline-based model.
module tb_mmio_timer;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        sel;
  logic [31:0] rdata;
  logic        irq;

  int n_chk;
  int n_err;
  bit started;

  mmio_timer dut (
    .clk    (clk),
    .reset  (rst_n),
    .addr   (addr),
    .wdata  (wdata),
    .byteen (byteen),
    .sel    (sel),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: the timer is described by a timeline. When engaged, t counts cycles
  // since the LOAD cycle (t=0); COUNT is n0-(t-1) clipped at 0 and the
  // interrupt cycle falls at t = max(n0,1)+1.
  bit          m_en, m_im, m_pend, m_run;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  longint      m_t, m_n, m_n0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_in_int();
    return m_run && (m_t != 0) && (m_t == m_n + 1);
  endfunction

  task automatic model_update();
    bit          clr_en;
    logic [31:0] np;
    if (!rst_n) begin
      m_en = 0; m_im = 0; m_pend = 0; m_run = 0; m_mode = 2'b00;
      m_preset = 0; m_count = 0; m_t = 0; m_n = 1; m_n0 = 0;
      return;
    end
    clr_en = 0;
    np = m_preset;
    if (sel && byteen != 0 && addr[3:2] == 2'd1) begin
      for (int k = 0; k < 4; k++) if (byteen[k]) np[8*k +: 8] = wdata[8*k +: 8];
    end
    if (!m_run) begin
      if (m_en) begin m_run = 1; m_t = 0; end
    end else if (m_t == 0) begin
      m_n0 = m_preset;
      m_n = (m_preset == 0) ? 1 : longint'(m_preset);
      m_count = m_preset;
      m_t = 1;
    end else if (m_t <= m_n) begin
      if (!m_en) m_run = 0;
      else begin
        m_t++;
        m_count = (m_n0 >= m_t - 1) ? 32'(m_n0 - (m_t - 1)) : 32'd0;
      end
    end else begin
      if (m_mode == 2'b01) m_t = 0;
      else begin m_run = 0; m_pend = 1; clr_en = 1; end
    end
    if (clr_en) m_en = 0;
    if (sel && byteen != 0 && addr[3:2] == 2'd0) begin
      m_pend = 0;
      if (byteen[0]) begin
        m_en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3];
      end
    end
    m_preset = np;
  endtask

  function automatic logic [31:0] m_rdata();
    if (!sel) return 32'd0;
    case (addr[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Every-cycle comparison against the model, well away from the clock edge.
  always @(negedge clk) begin
    #1;
    if (started) begin
      chk("rdata", rdata, m_rdata());
      chk("irq", {31'd0, irq}, {31'd0, m_im & (m_pend | (m_in_int() & (m_mode == 2'b01)))});
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be; sel = 1'b1;
    step();
    byteen = 4'b0000;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr = a; sel = 1'b1; byteen = 4'b0000;
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; byteen = 4'b0000;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; started = 0;
    rst_n = 1'b0; addr = 0; wdata = 0; byteen = 0; sel = 0;
    @(negedge clk); #2;
    do_reset();
    started = 1;

    // Reset state.
    rd_chk("rst_ctrl", 32'h0, 32'd0);
    rd_chk("rst_preset", 32'h4, 32'd0);
    step();
    rd_chk("rst_count", 32'h8, 32'd0);
    rd_chk("rst_resv", 32'hC, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Byte merge, COUNT read-only, sel=0 ignored.
    wr(32'h4, 32'h12345678, 4'b1111);
    wr(32'h5, 32'hFFFFFFFF, 4'b0001);
    rd_chk("bytemerge", 32'h4, 32'h123456FF);
    wr(32'h8, 32'hFFFFFFFF, 4'b1111);
    rd_chk("count_ro", 32'h8, 32'd0);
    addr = 32'h4; wdata = 32'h0; byteen = 4'b1111; sel = 1'b0;
    step();
    byteen = 4'b0000;
    rd_chk("sel0_ignored", 32'h4, 32'h123456FF);

    // One-shot, PRESET=5: COUNT 5..0, irq from cycle 8.
    wr(32'h4, 32'd5, 4'b1111);
    wr(32'h0, 32'h9, 4'b1111);
    addr = 32'h8; sel = 1'b1;
    step(); step();
    for (int k = 0; k < 6; k++) begin
      chk("os_count", rdata, 32'(5 - k));
      chk("os_irq_low", {31'd0, irq}, 32'd0);
      step();
    end
    chk("os_irq_high", {31'd0, irq}, 32'd1);
    rd_chk("os_ctrl", 32'h0, 32'h8);
    step();
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    wr(32'h0, 32'h8, 4'b0001);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: pulse every 5 cycles, then stop mid-count.
    wr(32'h4, 32'd3, 4'b1111);
    wr(32'h0, 32'hB, 4'b0001);
    addr = 32'h8;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("ar_pulse", {31'd0, irq}, {31'd0, (k % 5) == 0});
    end
    chk("ar_count3", rdata, 32'd3);
    rd_chk("ar_ctrl", 32'h0, 32'hB);
    wr(32'h0, 32'hA, 4'b0001);
    addr = 32'h8;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("ar_frozen", rdata, 32'd2);
      chk("ar_nopulse", {31'd0, irq}, 32'd0);
    end

    // One-shot with IM=0, then enable IM: PEND cleared by that write.
    do_reset();
    wr(32'h4, 32'd2, 4'b1111);
    wr(32'h0, 32'h1, 4'b0001);
    repeat (8) step();
    rd_chk("im0_ctrl", 32'h0, 32'h0);
    chk("im0_irq", {31'd0, irq}, 32'd0);
    wr(32'h0, 32'h8, 4'b0001);
    step();
    chk("im1_irq", {31'd0, irq}, 32'd0);

    // Reset mid-count.
    do_reset();
    wr(32'h4, 32'd5, 4'b1111);
    wr(32'h0, 32'h9, 4'b0001);
    addr = 32'h8;
    repeat (4) step();
    chk("mid_count3", rdata, 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_count", rdata, 32'd0);
    rd_chk("mid_rst_ctrl", 32'h0, 32'd0);
    rd_chk("mid_rst_preset", 32'h4, 32'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("mid_no_irq", {31'd0, irq}, 32'd0);
    end

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      sel = ($urandom_range(0, 7) != 0);
      addr = $urandom;
      byteen = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      wdata = $urandom;
      if (addr[3:2] == 2'd1 && $urandom_range(0, 3) != 0) wdata = $urandom_range(0, 9);
      if (addr[3:2] == 2'd0) wdata[0] = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
